breakout_debug_ocimem: RTL

On-chip debug memory engine for the breakout processor's JTAG debug path. It sits directly downstream of the debug-slave system-clock stage. It consumes that stage's `jdo` word and `take_*_ocimem_*` strobes to read and write a small debug RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave TCK stage. It also exposes the same RAM plus a status register to the CPU's debug monitor code through an Avalon-MM slave.

---
 rtl/breakout_debug_pkg.sv | 23 ++
 rtl/breakout_debug_ocimem_ram.sv | 24 ++
 rtl/breakout_debug_ocimem.sv | 138 +++++++++++++
 3 files changed

// File: rtl/breakout_debug_pkg.sv
// Shared types and jdo field positions for the breakout OCI debug memory engine.
package breakout_debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    J_RD,
    J_CAP,
    J_WR,
    C_RD
  } ocimem_state_e;

  localparam int JDO_W          = 38;
  localparam int JDO_CLR_STATUS = 35;
  localparam int JDO_WDATA_HI   = 34;
  localparam int JDO_WDATA_LO   = 3;
  localparam int JDO_ADDR_LO    = 2;

  localparam int STAT_READY = 0;
  localparam int STAT_ERROR = 1;

  localparam int WORD_W = 32;

endpackage

// File: rtl/breakout_debug_ocimem_ram.sv
// Single-port debug RAM: synchronous one-cycle read, write-enable, no reset on contents.
module breakout_debug_ocimem_ram
  import breakout_debug_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WORD_W-1:0]     i_wdata,
  output logic [WORD_W-1:0]     o_q
);

  logic [WORD_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [WORD_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_q <= r_mem[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/breakout_debug_ocimem.sv
// JTAG/CPU arbitrated debug memory engine. Define BREAKOUT_OCIMEM_AUTOINC_EN to make the
// JTAG address post-increment after every JTAG read capture and write (burst dump/load).
module breakout_debug_ocimem
  import breakout_debug_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [JDO_W-1:0]      jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic [DEPTH_LOG2:0]   avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [WORD_W-1:0]     avs_writedata,
  output logic [WORD_W-1:0]     avs_readdata,
  output logic                  avs_waitrequest,
  output logic [WORD_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);

  ocimem_state_e          r_state, w_next;
  logic [DEPTH_LOG2-1:0]  r_addr;
  logic [WORD_W-1:0]      r_wdata;
  logic                   r_csel;
  logic [WORD_W-1:0]      r_mondreg;
  logic                   r_ready, r_error;

  logic                   w_strobe, w_cpu_req, w_stat_wr, w_cpu_rd_go;
  logic                   w_ram_we;
  logic [DEPTH_LOG2-1:0]  w_ram_addr;
  logic [WORD_W-1:0]      w_ram_wdata, w_ram_q;
  logic                   w_unused_jdo;

  assign w_strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_cpu_req    = avs_read | avs_write;
  assign w_unused_jdo = &{1'b0, jdo[JDO_W-1:JDO_CLR_STATUS+1], jdo[JDO_ADDR_LO-1:0]};

  breakout_debug_ocimem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_q     (w_ram_q)
  );

  always_comb begin
    w_next          = r_state;
    w_ram_we        = 1'b0;
    w_ram_addr      = r_addr;
    w_ram_wdata     = avs_writedata;
    w_stat_wr       = 1'b0;
    w_cpu_rd_go     = 1'b0;
    avs_waitrequest = w_cpu_req;
    avs_readdata    = '0;
    case (r_state)
      IDLE: begin
        avs_waitrequest = 1'b0;
        if (take_action_ocimem_a || take_no_action_ocimem_a) begin
          w_next = J_RD;
        end else if (take_action_ocimem_b) begin
          w_next = J_WR;
        end else if (avs_write) begin
          if (avs_address[DEPTH_LOG2]) begin
            w_stat_wr = 1'b1;
          end else begin
            w_ram_we   = 1'b1;
            w_ram_addr = avs_address[DEPTH_LOG2-1:0];
          end
        end else if (avs_read) begin
          avs_waitrequest = 1'b1;
          w_ram_addr      = avs_address[DEPTH_LOG2-1:0];
          w_cpu_rd_go     = 1'b1;
          w_next          = C_RD;
        end
        // JTAG owns the RAM port this cycle; the CPU request stays pending.
        if (w_strobe && w_cpu_req) avs_waitrequest = 1'b1;
      end
      J_RD:  w_next = J_CAP;
      J_CAP: w_next = IDLE;
      J_WR: begin
        w_ram_we    = 1'b1;
        w_ram_wdata = r_wdata;
        w_next      = IDLE;
      end
      C_RD: begin
        avs_waitrequest = avs_write & ~avs_read;
        avs_readdata    = r_csel ? {30'b0, r_error, r_ready} : w_ram_q;
        w_next          = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_csel    <= 1'b0;
      r_mondreg <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && take_action_ocimem_a) begin
        r_addr <= jdo[DEPTH_LOG2+1:JDO_ADDR_LO];
        if (jdo[JDO_CLR_STATUS]) begin
          r_ready <= 1'b0;
          r_error <= 1'b0;
        end
      end
      if (w_cpu_rd_go) r_csel <= avs_address[DEPTH_LOG2];
      if (r_state == J_CAP) r_mondreg <= w_ram_q;
`ifdef BREAKOUT_OCIMEM_AUTOINC_EN
      if (r_state == J_CAP || r_state == J_WR) r_addr <= r_addr + 1'b1;
`endif
      if (w_strobe && r_state != IDLE) r_error <= 1'b1;
      // Later assignments win, so a CPU set beats a same-cycle JTAG clear.
      if (w_stat_wr) begin
        if (avs_writedata[STAT_READY]) r_ready <= 1'b1;
        if (avs_writedata[STAT_ERROR]) r_error <= 1'b1;
      end
    end
  end

  // Write data is captured at the strobe so jdo may move on during J_WR.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && take_action_ocimem_b) r_wdata <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
  end

  assign MonDReg       = r_mondreg;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

endmodule
